// File: rtl/param_smpl_queue.sv
// param_smpl_queue: decimating ring-buffer sample queue that bursts out the
// newest WIN samples, oldest first, each time a new sample is stored.
module param_smpl_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 1024,
  parameter int WIN = 1021,
  parameter int DECIM = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          new_smpl,
  input  logic                       valid_rise,
  input  logic                       flush,
  output logic [DATA_W-1:0]          smpl_out,
  output logic                       smpl_vld,
  output logic                       sequencing,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic [$clog2(WIN+1)-1:0]   fill_cnt,
  output logic                       overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(WIN + 1);
  localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
  typedef enum logic [1:0] {FILL, WAIT, SEQ} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d, iss_cnt_q, iss_cnt_d;
  logic [CW-1:0] dec_cnt_q, dec_cnt_d;
  logic overrun_q, overrun_d, vld_q, vld_d, start_q, start_d, done_q, done_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic wrt_en, busy, trig, last;
  always_comb begin
    wrt_en = valid_rise & (dec_cnt_q == '0) & ~flush;
    busy = (state_q == SEQ) | vld_q;
    last = iss_cnt_q == FW'(WIN - 1);
    trig = wrt_en & ~busy & (fill_cnt_q >= FW'(WIN - 1));
    dec_cnt_d = flush ? '0 : valid_rise ? (dec_cnt_q == CW'(DECIM - 1) ? '0 : dec_cnt_q + 1'b1) : dec_cnt_q;
    wr_ptr_d = flush ? '0 : wrt_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_cnt_d = flush ? '0 : (wrt_en && fill_cnt_q != FW'(WIN)) ? fill_cnt_q + 1'b1 : fill_cnt_q;
    overrun_d = ~flush & (overrun_q | (wrt_en & busy));
    state_d = state_q;
    rd_ptr_d = rd_ptr_q;
    iss_cnt_d = iss_cnt_q;
    // window ends on the slot being written this cycle
    if (trig) begin
      state_d = SEQ;
      rd_ptr_d = wr_ptr_q + 1'b1 - AW'(WIN);
      iss_cnt_d = '0;
    end else if (state_q == SEQ) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      iss_cnt_d = iss_cnt_q + 1'b1;
      state_d = last ? WAIT : SEQ;
    end
    if (flush) begin
      state_d = FILL;
      rd_ptr_d = '0;
      iss_cnt_d = '0;
    end
    vld_d = ~flush & (state_q == SEQ);
    start_d = vld_d & (iss_cnt_q == '0);
    done_d = vld_d & last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_cnt_q <= '0;
      iss_cnt_q <= '0;
      dec_cnt_q <= '0;
      overrun_q <= 1'b0;
      vld_q <= 1'b0;
      start_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      overrun_q <= overrun_d;
      vld_q <= vld_d;
      start_q <= start_d;
      done_q <= done_d;
    end
  always_ff @(posedge clk) begin
    if (wrt_en) mem[wr_ptr_q] <= new_smpl;
    rd_data_q <= mem[rd_ptr_q];
  end
  assign smpl_out = vld_q ? rd_data_q : '0;
  assign smpl_vld = vld_q;
  assign sequencing = busy;
  assign frame_start = start_q;
  assign frame_done = done_q;
  assign fill_cnt = fill_cnt_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_param_smpl_queue.sv
// tb_param_smpl_queue: three queue configurations driven by shared stimulus,
// each checked every cycle against a window/queue reference model.
module tb_param_smpl_queue;
  logic clk = 0, rst = 1, vr = 0, flush = 0;
  logic [15:0] din = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D = g == 2 ? 1024 : 16;
    localparam int W = g == 2 ? 1021 : 13;
    localparam int M = g == 1 ? 1 : 2;
    logic [$clog2(W+1)-1:0] fc;
    logic [15:0] so;
    logic sv, sq, fs, fd, ov;
    int ns = 0, nd = 0, nv = 0;
    param_smpl_queue #(.DATA_W(16), .DEPTH(D), .WIN(W), .DECIM(M)) dut (
      .clk(clk), .rst(rst), .new_smpl(din), .valid_rise(vr), .flush(flush),
      .smpl_out(so), .smpl_vld(sv), .sequencing(sq), .frame_start(fs),
      .frame_done(fd), .fill_cnt(fc), .overrun(ov));
    logic [15:0] hist[$];
    logic [15:0] win[$];
    int wt[$];
    int fill = 0, dec = 0, fr_t = 0, cyc = 0;
    bit fr_on = 0, ovr = 0;
    always @(posedge clk or posedge rst) begin
      if (rst || flush) begin
        hist = {}; fill = 0; dec = 0; fr_on = 0; ovr = 0;
      end else if (vr) begin
        if (dec == 0) begin
          hist.push_back(din);
          if (hist.size() > D) void'(hist.pop_front());
          if (fill < W) fill++;
          if (fr_on && cyc >= fr_t + 1 && cyc <= fr_t + 1 + W) begin
            ovr = 1;
            wt.push_back(cyc);
          end else if (fill == W) begin
            fr_on = 1; fr_t = cyc; wt = {}; win = {};
            for (int i = hist.size() - W; i < hist.size(); i++) win.push_back(hist[i]);
          end
        end
        dec = (dec + 1) % M;
      end
      if (!rst) cyc++;
    end
    // slot k is only trusted if the write that reuses its address came no earlier than its read
    always @(negedge clk) begin
      int k, j;
      bit e_vld, e_ok;
      k = cyc - fr_t - 2;
      e_vld = fr_on && k >= 0 && k < W;
      j = D - W + 1 + k;
      e_ok = !(e_vld && wt.size() >= j && wt[j-1] < fr_t + 1 + k);
      chk("smpl_vld", g, 32'(sv), 32'(e_vld));
      chk("sequencing", g, 32'(sq), 32'(fr_on && cyc >= fr_t + 1 && cyc <= fr_t + 1 + W));
      chk("frame_start", g, 32'(fs), 32'(e_vld && k == 0));
      chk("frame_done", g, 32'(fd), 32'(e_vld && k == W - 1));
      chk("fill_cnt", g, 32'(fc), 32'(fill));
      chk("overrun", g, 32'(ov), 32'(ovr));
      if (e_ok) chk("smpl_out", g, 32'(so), e_vld ? 32'(win[k]) : 32'd0);
      ns += int'(fs);
      nd += int'(fd);
      nv += int'(sv);
    end
  end
  typedef struct { logic [15:0] smpl; int exp_fill; } vec_t;
  vec_t tbl[25];
  task automatic pulse(input logic [15:0] d, input int gap);
    vr = 1; din = d;
    @(posedge clk); #1;
    vr = 0;
    repeat (gap) @(posedge clk);
    #1;
  endtask
  task automatic do_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
  endtask
  task automatic apply_tbl();
    for (int i = 0; i < 25; i++) begin
      pulse(tbl[i].smpl, 2);
      chk("tbl_fill", 0, 32'(u[0].fc), tbl[i].exp_fill);
    end
  endtask
  task automatic prime_trig();
    for (int i = 0; i < 24; i++) pulse(16'(100 + i), 2);
    pulse(16'h7fff, 0);
  endtask
  task automatic wait_vld(input int n);
    int seen = 0;
    for (int i = 0; i < 60 && seen < n; i++) begin
      @(negedge clk);
      if (u[0].sv) seen++;
    end
    chk("wait_vld", 0, seen, n);
  endtask
  initial begin
    int b0, b1, b2, v2;
    for (int i = 0; i < 25; i++) tbl[i] = '{16'(i + 1), (i / 2 + 1 < 13) ? i / 2 + 1 : 13};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fill", 0, 32'(u[0].fc), 0);
    chk("rst_vld", 0, 32'(u[0].sv), 0);
    rst = 0;
    apply_tbl();
    repeat (16) @(posedge clk);
    #1;
    chk("prime_frames", 0, u[0].ns, 1);
    chk("prime_vld", 0, u[0].nv, 13);
    for (int v = 26; v <= 61; v++) pulse(16'(v), 7);
    repeat (16) @(posedge clk);
    #1;
    chk("steady_frames", 0, u[0].ns, 19);
    chk("steady_ovr", 0, 32'(u[0].ov), 0);
    do_flush();
    b1 = u[1].ns; v2 = u[1].nv;
    for (int i = 0; i < 12; i++) pulse(16'(16'h8000 + i), 2);
    pulse(16'h1234, 0);
    for (int i = 0; i < 5; i++) pulse(16'(16'hf000 + i), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_set", 1, 32'(u[1].ov), 1);
    chk("ovr_frames", 1, u[1].ns - b1, 1);
    chk("ovr_vld", 1, u[1].nv - v2, 13);
    do_flush();
    chk("flush_ovr", 1, 32'(u[1].ov), 0);
    chk("flush_fill0", 0, 32'(u[0].fc), 0);
    chk("flush_fill1", 1, 32'(u[1].fc), 0);
    chk("flush_fill2", 2, 32'(u[2].fc), 0);
    prime_trig();
    wait_vld(5);
    b0 = u[0].nd;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("mid_flush_vld", 0, 32'(u[0].sv), 0);
    chk("mid_flush_seq", 0, 32'(u[0].sq), 0);
    b2 = u[0].ns;
    for (int i = 0; i < 24; i++) pulse(16'(16'h4000 + i), 2);
    chk("refill_done", 0, u[0].nd - b0, 0);
    chk("refill_fill", 0, 32'(u[0].fc), 12);
    chk("refill_nofr", 0, u[0].ns - b2, 0);
    pulse(16'h4444, 20);
    chk("refill_frame", 0, u[0].ns - b2, 1);
    do_flush();
    prime_trig();
    wait_vld(7);
    #2 rst = 1;
    #1;
    chk("rst_mid_vld", 0, 32'(u[0].sv), 0);
    chk("rst_mid_seq", 0, 32'(u[0].sq), 0);
    chk("rst_mid_out", 0, 32'(u[0].so), 0);
    chk("rst_mid_fill", 0, 32'(u[0].fc), 0);
    @(posedge clk); #1;
    rst = 0;
    b0 = u[0].ns;
    apply_tbl();
    repeat (16) @(posedge clk);
    #1;
    chk("rst_prime_frames", 0, u[0].ns - b0, 1);
    for (int i = 0; i < 3000; i++) begin
      vr = $urandom_range(3) == 0;
      din = 16'($urandom);
      flush = $urandom_range(199) == 0;
      @(posedge clk); #1;
    end
    vr = 0; flush = 0;
    do_flush();
    b2 = u[2].ns; v2 = u[2].nv;
    for (int i = 0; i < 2040; i++) pulse(16'($urandom), 1);
    chk("dflt_nofr", 2, u[2].ns - b2, 0);
    pulse(16'($urandom), 1);
    repeat (1040) @(posedge clk);
    #1;
    chk("dflt_frames", 2, u[2].ns - b2, 1);
    chk("dflt_vld", 2, u[2].nv - v2, 1021);
    chk("dflt_fill", 2, 32'(u[2].fc), 1021);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
